// File: rtl/operand_fetch_if.sv
// operand_fetch_if: issue-side (in_*) and execute-side (out_*) valid/ready bundle.
// master = issuer/consumer environment, slave = the operand_fetch stage.
interface operand_fetch_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int OPCODE_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] in_opcode;
  logic [ADDR_WIDTH-1:0]   in_rs1;
  logic [ADDR_WIDTH-1:0]   in_rs2;
  logic [ADDR_WIDTH-1:0]   in_rd;
  logic                    in_rd_we;

  logic                    out_valid;
  logic                    out_ready;
  logic [OPCODE_WIDTH-1:0] out_opcode;
  logic [ADDR_WIDTH-1:0]   out_rd;
  logic                    out_rd_we;
  logic [DATA_WIDTH-1:0]   out_op1;
  logic [DATA_WIDTH-1:0]   out_op2;

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_rd_we,
    input  in_ready,
    input  out_valid, out_opcode, out_rd, out_rd_we, out_op1, out_op2,
    output out_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_rd_we,
    output in_ready,
    output out_valid, out_opcode, out_rd, out_rd_we, out_op1, out_op2,
    input  out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reads rs1/rs2 from the 16x32 regfile, forwards writebacks,
// and buffers one instruction toward execute.
// Ports: clk, rst_n (async, active-low), bus (operand_fetch_if.slave),
// rf_read_addr1/2 -> regfile, rf_read_data1/2 <- regfile (registered read),
// wb_enable/wb_addr/wb_data snoop of the regfile write port.
// Optional: define OPERAND_FETCH_SCOREBOARD_EN for busy-bit RAW stalls.
module operand_fetch #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int OPCODE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_fetch_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  input  logic                  wb_enable,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  typedef enum logic [1:0] {
    EMPTY,
    FRESH,
    HELD
  } state_t;

  state_t state_q, state_d;

  logic                    valid_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic                    rd_we_q;
  logic [ADDR_WIDTH-1:0]   rs1_q, rs2_q;
  logic                    byp1_q, byp2_q;
  logic [DATA_WIDTH-1:0]   bypd1_q, bypd2_q;
  logic [DATA_WIDTH-1:0]   hold1_q, hold2_q;
  logic [DATA_WIDTH-1:0]   cur1, cur2;

  logic accept, hs, sb_ok;
  logic in_hit1, in_hit2;
  logic wb_hit1, wb_hit2;

  assign rf_read_addr1 = bus.in_rs1;
  assign rf_read_addr2 = bus.in_rs2;

  // regfile returns pre-write data when read and written on one edge
  assign in_hit1 = wb_enable && (wb_addr == bus.in_rs1);
  assign in_hit2 = wb_enable && (wb_addr == bus.in_rs2);
  assign wb_hit1 = wb_enable && (wb_addr == rs1_q);
  assign wb_hit2 = wb_enable && (wb_addr == rs2_q);

`ifdef OPERAND_FETCH_SCOREBOARD_EN
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;
  logic            rs1_free, rs2_free, rd_free;

  // a writeback this cycle releases its register for the new instruction
  assign rs1_free = !busy_q[bus.in_rs1] ||
                    (wb_enable && (wb_addr == bus.in_rs1));
  assign rs2_free = !busy_q[bus.in_rs2] ||
                    (wb_enable && (wb_addr == bus.in_rs2));
  assign rd_free  = !busy_q[bus.in_rd] ||
                    (wb_enable && (wb_addr == bus.in_rd));
  assign sb_ok    = rs1_free && rs2_free &&
                    (!bus.in_rd_we || rd_free);

  always_comb begin
    busy_d = busy_q;
    if (wb_enable)
      busy_d[wb_addr] = 1'b0;
    if (accept && bus.in_rd_we)
      busy_d[bus.in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end
`else
  assign sb_ok = 1'b1;
`endif

  assign bus.in_ready = ((state_q == EMPTY) || bus.out_ready) && sb_ok;
  assign accept       = bus.in_valid && bus.in_ready;
  assign hs           = valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cur1    = '0;
    cur2    = '0;
    unique case (state_q)
      EMPTY: begin
        if (accept)
          state_d = FRESH;
      end
      FRESH: begin
        cur1 = byp1_q ? bypd1_q : rf_read_data1;
        cur2 = byp2_q ? bypd2_q : rf_read_data2;
        if (hs)
          state_d = accept ? FRESH : EMPTY;
        else
          state_d = HELD;
      end
      HELD: begin
        cur1 = hold1_q;
        cur2 = hold2_q;
        if (hs)
          state_d = accept ? FRESH : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      byp1_q   <= 1'b0;
      byp2_q   <= 1'b0;
      bypd1_q  <= '0;
      bypd2_q  <= '0;
      hold1_q  <= '0;
      hold2_q  <= '0;
    end else begin
      if (accept) begin
        opcode_q <= bus.in_opcode;
        rd_q     <= bus.in_rd;
        rd_we_q  <= bus.in_rd_we;
        rs1_q    <= bus.in_rs1;
        rs2_q    <= bus.in_rs2;
        byp1_q   <= in_hit1;
        byp2_q   <= in_hit2;
        bypd1_q  <= wb_data;
        bypd2_q  <= wb_data;
      end
      // entry stays: capture current operand, or a write that lands now
      if ((state_q != EMPTY) && !hs) begin
        hold1_q <= wb_hit1 ? wb_data : cur1;
        hold2_q <= wb_hit2 ? wb_data : cur2;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_opcode = opcode_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_rd_we  = rd_we_q;
  assign bus.out_op1    = cur1;
  assign bus.out_op2    = cur2;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed table, corner sequences and random run
// against an architectural-register / queue reference model.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int OW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)
  ) bus ();

  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic          wb_en;
  logic [AW-1:0] wb_a;
  logic [DW-1:0] wb_d;

  operand_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .rf_read_addr1 (ra1),
    .rf_read_addr2 (ra2),
    .rf_read_data1 (rd1),
    .rf_read_data2 (rd2),
    .wb_enable     (wb_en),
    .wb_addr       (wb_a),
    .wb_data       (wb_d)
  );

  // register file with registered read
  logic [DW-1:0] rf [16] = '{default: '0};
  always @(posedge clk) begin
    rd1 <= rf[ra1];
    rd2 <= rf[ra2];
    if (wb_en) rf[wb_a] <= wb_d;
  end

  // architectural state seen by the reference model
  logic [DW-1:0] arch [16] = '{default: '0};
  always @(posedge clk)
    if (wb_en) arch[wb_a] <= wb_d;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] opc,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic we,
                       input logic wen, input logic [3:0] wa,
                       input logic [31:0] wd, input logic ordy);
    bus.in_valid  = v;
    bus.in_opcode = opc;
    bus.in_rs1    = s1;
    bus.in_rs2    = s2;
    bus.in_rd     = d;
    bus.in_rd_we  = we;
    wb_en         = wen;
    wb_a          = wa;
    wb_d          = wd;
    bus.out_ready = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0,
          1'b0, 4'd0, 32'h0, ordy);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle(1'b1);
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  opc;
    logic [3:0]  rs1, rs2, rd;
    logic        we;
    logic        wen;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ordy;
    logic        e_valid;
    logic        e_irdy;
    logic [7:0]  e_opc;
    logic [31:0] e_op1, e_op2;
  } vec_t;

  typedef struct {
    logic [7:0] opc;
    logic [3:0] rs1, rs2, rd;
    logic       we;
  } ins_t;

  vec_t tbl [9];
  ins_t q [$];
  logic busy [16];

  initial begin
    tbl[0] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3,
               32'h11, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 8'hA1, 4'd3, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 8'hA2, 4'd3, 4'd3, 4'd2, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b1, 1'b1, 1'b1, 8'hA1, 32'h11, 32'h0};
    tbl[3] = '{1'b1, 8'hA3, 4'd5, 4'd0, 4'd3, 1'b1, 1'b1, 4'd5,
               32'hDEAD, 1'b1, 1'b1, 1'b1, 8'hA2, 32'h11, 32'h11};
    tbl[4] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b0, 1'b1, 1'b0, 8'hA3, 32'hDEAD, 32'h0};
    tbl[5] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5,
               32'hBEEF, 1'b0, 1'b1, 1'b0, 8'hA3, 32'hDEAD, 32'h0};
    tbl[6] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b0, 1'b1, 1'b0, 8'hA3, 32'hBEEF, 32'h0};
    tbl[7] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b1, 1'b1, 1'b1, 8'hA3, 32'hBEEF, 32'h0};
    tbl[8] = '{1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,
               32'h0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0};

    // reset state
    idle(1'b1);
    step();
    step();
    chk("rst_valid",  bus.out_valid, 1'b0);
    chk("rst_opcode", bus.out_opcode, 8'h00);
    chk("rst_op1",    bus.out_op1, 32'h0);
    chk("rst_irdy",   bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // directed table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].opc, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].we, tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("t%0d_valid", i), bus.out_valid, tbl[i].e_valid);
      chk($sformatf("t%0d_irdy", i), bus.in_ready, tbl[i].e_irdy);
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_opc", i), bus.out_opcode, tbl[i].e_opc);
        chk($sformatf("t%0d_op1", i), bus.out_op1, tbl[i].e_op1);
        chk($sformatf("t%0d_op2", i), bus.out_op2, tbl[i].e_op2);
      end
      step();
    end

    // asynchronous reset while HELD
    drive(1'b1, 8'h5C, 4'd5, 4'd3, 4'd9, 1'b1,
          1'b0, 4'd0, 32'h0, 1'b0);
    step();
    idle(1'b0);
    step();
    step();
    chk("held_valid", bus.out_valid, 1'b1);
    chk("held_op1", bus.out_op1, 32'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_opc", bus.out_opcode, 8'h00);
    chk("arst_rd", bus.out_rd, 4'd0);
    chk("arst_we", bus.out_rd_we, 1'b0);
    chk("arst_op1", bus.out_op1, 32'h0);
    chk("arst_op2", bus.out_op2, 32'h0);
    step();
    rst_n = 1'b1;
    idle(1'b1);
    @(negedge clk);
    chk("arst_irdy", bus.in_ready, 1'b1);
    step();

    // RAW on r7: stall with scoreboard, stale value without
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0,
          1'b1, 4'd7, 32'h77, 1'b1);
    step();
    drive(1'b1, 8'h71, 4'd0, 4'd0, 4'd7, 1'b1,
          1'b0, 4'd0, 32'h0, 1'b1);
    @(negedge clk);
    chk("raw_first_irdy", bus.in_ready, 1'b1);
    step();
    drive(1'b1, 8'h72, 4'd7, 4'd0, 4'd0, 1'b0,
          1'b0, 4'd0, 32'h0, 1'b1);
    @(negedge clk);
`ifdef OPERAND_FETCH_SCOREBOARD_EN
    chk("raw_stall0", bus.in_ready, 1'b0);
    step();
    @(negedge clk);
    chk("raw_stall1", bus.in_ready, 1'b0);
    drive(1'b1, 8'h72, 4'd7, 4'd0, 4'd0, 1'b0,
          1'b1, 4'd7, 32'h42, 1'b1);
    #1;
    chk("raw_release", bus.in_ready, 1'b1);
    step();
    idle(1'b1);
    @(negedge clk);
    chk("raw_valid", bus.out_valid, 1'b1);
    chk("raw_opc", bus.out_opcode, 8'h72);
    chk("raw_op1", bus.out_op1, 32'h42);
`else
    chk("raw_noblock", bus.in_ready, 1'b1);
    step();
    idle(1'b1);
    @(negedge clk);
    chk("raw_valid", bus.out_valid, 1'b1);
    chk("raw_opc", bus.out_opcode, 8'h72);
    chk("raw_op1", bus.out_op1, 32'h77);
`endif
    step();

    // random run against reference model
    do_reset();
    q.delete();
    for (int i = 0; i < 16; i++) busy[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        v, we, wen, ordy, exp_irdy, acc, hs, sfree;
      logic [3:0]  s1, s2, d, wa;
      logic [7:0]  opc;
      logic [31:0] wd;
      ins_t        it;
      v    = ($urandom_range(3) != 0);
      opc  = 8'($urandom);
      s1   = 4'($urandom_range(3));
      s2   = 4'($urandom_range(3));
      d    = 4'($urandom_range(3));
      we   = 1'($urandom_range(1));
      wen  = 1'($urandom_range(1));
      wa   = 4'($urandom_range(3));
      wd   = $urandom;
      ordy = ($urandom_range(3) != 0);
      drive(v, opc, s1, s2, d, we, wen, wa, wd, ordy);
      @(negedge clk);
`ifdef OPERAND_FETCH_SCOREBOARD_EN
      sfree = (!busy[s1] || (wen && wa == s1)) &&
              (!busy[s2] || (wen && wa == s2)) &&
              (!we || !busy[d] || (wen && wa == d));
`else
      sfree = 1'b1;
`endif
      exp_irdy = ((q.size() == 0) || ordy) && sfree;
      chk("r_irdy", bus.in_ready, exp_irdy);
      chk("r_raddr1", ra1, s1);
      chk("r_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("r_opc", bus.out_opcode, q[0].opc);
        chk("r_rd", bus.out_rd, q[0].rd);
        chk("r_we", bus.out_rd_we, q[0].we);
        chk("r_op1", bus.out_op1, arch[q[0].rs1]);
        chk("r_op2", bus.out_op2, arch[q[0].rs2]);
      end
      acc = v && exp_irdy;
      hs  = (q.size() != 0) && ordy;
      @(posedge clk);
      if (hs) void'(q.pop_front());
      if (acc) begin
        it.opc = opc;
        it.rs1 = s1;
        it.rs2 = s2;
        it.rd  = d;
        it.we  = we;
        q.push_back(it);
      end
      if (wen) busy[wa] = 1'b0;
      if (acc && we) busy[d] = 1'b1;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
